// File: rtl/ram_dp_clr.sv
// Dual-port word RAM: combinational CPU read with byte-masked write, registered
// display read, and a sequential clear engine that zeroes the array.
module ram_dp_clr #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   d,
  output logic [DATA_WIDTH-1:0]   q,
  input  logic                    disp_re,
  input  logic [ADDR_WIDTH-1:0]   disp_addr,
  output logic [DATA_WIDTH-1:0]   disp_q,
  output logic                    disp_valid,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic                    clr_wr_c;
  logic                    cpu_wr_c;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   disp_q_q;
  logic                    disp_valid_q;

  // State and sweep pointer; reset decides whether a sweep runs first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state; the wide pointer keeps the terminal compare from wrapping
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_wr_c = 1'b0;
    cpu_wr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_wr_c = we;
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_wr_c = 1'b1;
        if (ptr_q == PW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Array write port: clear sweep has priority, CPU writes dropped while busy
  always_ff @(posedge clk) begin
    if (clr_wr_c) begin
      mem[ptr_q[ADDR_WIDTH-1:0]] <= '0;
    end else if (cpu_wr_c) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

  // Display port samples the pre-edge word, giving read-before-write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_q_q     <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_valid_q <= disp_re;
      if (disp_re) disp_q_q <= mem[disp_addr];
    end
  end

  assign q          = mem[addr];
  assign disp_q     = disp_q_q;
  assign disp_valid = disp_valid_q;
  assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr (16 x 32, auto-clear): directed table, corner sequences
// and random traffic checked against a word-array reference model.
module tb_ram_dp_clr;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [3:0]    be = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] d = '0;
  logic [DW-1:0] q;
  logic          disp_re = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_q;
  logic          disp_valid;
  logic          clr_req = 1'b0;
  logic          busy;

  ram_dp_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .be(be), .addr(addr), .d(d), .q(q),
    .disp_re(disp_re), .disp_addr(disp_addr), .disp_q(disp_q),
    .disp_valid(disp_valid), .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain word array plus a "sweep in progress" counter
  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  bit            m_busy;
  int            m_ptr;
  logic [DW-1:0] m_dq;
  bit            m_dq_known;
  bit            m_dv;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic          dre;
    logic [AW-1:0] daddr;
    logic [DW-1:0] eq;
    logic [DW-1:0] edq;
    logic          edv;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock with the current inputs; model advances, then outputs are checked
  task automatic step();
    if (disp_re) begin
      m_dv       = 1'b1;
      m_dq       = model[disp_addr];
      m_dq_known = known[disp_addr];
    end else begin
      m_dv = 1'b0;
    end
    if (m_busy) begin
      model[m_ptr] = '0;
      known[m_ptr] = 1'b1;
      m_ptr++;
      if (m_ptr == DEPTH) m_busy = 1'b0;
    end else begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[addr][8*i +: 8] = d[8*i +: 8];
        if (be == 4'hF) known[addr] = 1'b1;
      end
      if (clr_req) begin
        m_busy = 1'b1;
        m_ptr  = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("busy", DW'(busy), DW'(m_busy));
    chk("disp_valid", DW'(disp_valid), DW'(m_dv));
    if (m_dq_known) chk("disp_q", disp_q, m_dq);
    if (known[addr]) chk("q", q, model[addr]);
  endtask

  task automatic idle_inputs();
    we = 1'b0; be = '0; d = '0; clr_req = 1'b0; disp_re = 1'b0;
  endtask

  // Step until busy drops (bounded), returning the number of busy cycles
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      addr = AW'(a);
      #1;
      chk(name, q, '0);
    end
  endtask

  task automatic model_reset();
    m_dq = '0; m_dq_known = 1'b1; m_dv = 1'b0; m_busy = 1'b1; m_ptr = 0;
  endtask

  task automatic fill_ones();
    for (int a = 0; a < DEPTH; a++) begin
      we = 1'b1; be = 4'hF; addr = AW'(a); d = 32'hFFFFFFFF;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    int n;
    for (int a = 0; a < DEPTH; a++) begin
      model[a] = '0;
      known[a] = 1'b0;
    end
    // we  be     addr   d              dre  daddr  exp_q          exp_dq         exp_dv
    tbl[0]  = '{1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 4'd0, 32'hAABBCCDD, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 4'h5, 4'd5, 32'h11223344, 1'b0, 4'd0, 32'hAA22CC44, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 4'hF, 4'd7, 32'h00000001, 1'b1, 4'd7, 32'h00000001, 32'h0,        1'b1};
    tbl[3]  = '{1'b0, 4'h0, 4'd7, 32'h0,        1'b1, 4'd7, 32'h00000001, 32'h1,        1'b1};
    tbl[4]  = '{1'b1, 4'hF, 4'd2, 32'hCAFEF00D, 1'b0, 4'd0, 32'hCAFEF00D, 32'h1,        1'b0};
    tbl[5]  = '{1'b1, 4'hF, 4'd4, 32'h0BADBEEF, 1'b0, 4'd0, 32'h0BADBEEF, 32'h1,        1'b0};
    tbl[6]  = '{1'b0, 4'h0, 4'd4, 32'h0,        1'b1, 4'd2, 32'h0BADBEEF, 32'hCAFEF00D, 1'b1};
    tbl[7]  = '{1'b0, 4'h0, 4'd4, 32'h0,        1'b0, 4'd9, 32'h0BADBEEF, 32'hCAFEF00D, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 4'd4, 32'h0,        1'b1, 4'd4, 32'h0BADBEEF, 32'h0BADBEEF, 1'b1};
    tbl[9]  = '{1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, 1'b0, 4'd0, 32'hAA22CC44, 32'h0BADBEEF, 1'b0};
    tbl[10] = '{1'b1, 4'h8, 4'd5, 32'h12345678, 1'b0, 4'd0, 32'h1222CC44, 32'h0BADBEEF, 1'b0};

    // Power-on reset and automatic sweep
    #1 rst = 1'b0;
    model_reset();
    #2;
    chk("rst_disp_q", disp_q, '0);
    chk("rst_disp_valid", DW'(disp_valid), '0);
    chk("rst_busy", DW'(busy), 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    count_busy(n);
    chk("init_busy_len", n, 32'd16);
    check_all_zero("init_clear_q");

    // Directed vectors: byte masks, read-before-write, display gap
    foreach (tbl[i]) begin
      we = tbl[i].we; be = tbl[i].be; addr = tbl[i].addr; d = tbl[i].d;
      disp_re = tbl[i].dre; disp_addr = tbl[i].daddr;
      step();
      chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
      chk($sformatf("vec%0d_disp_q", i), disp_q, tbl[i].edq);
      chk($sformatf("vec%0d_disp_valid", i), DW'(disp_valid), DW'(tbl[i].edv));
    end
    idle_inputs();

    // Clear request over a full array with a CPU write attempted mid-sweep
    fill_ones();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      if (n == 5) begin
        we = 1'b1; be = 4'hF; addr = 4'd3; d = 32'hFFFFFFFF;
      end else begin
        we = 1'b0;
      end
      step();
      n++;
    end
    idle_inputs();
    chk("req_busy_len", n, 32'd16);
    check_all_zero("req_clear_q");

    // Reset in the middle of a sweep restarts it from word 0
    fill_ones();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    disp_re = 1'b1; disp_addr = 4'd15;
    repeat (8) step();
    chk("pre_rst_disp_q", disp_q, 32'hFFFFFFFF);
    rst = 1'b0;
    disp_re = 1'b0;
    model_reset();
    #1;
    chk("midrst_disp_valid", DW'(disp_valid), '0);
    chk("midrst_disp_q", disp_q, '0);
    chk("midrst_busy", DW'(busy), 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    count_busy(n);
    chk("midrst_busy_len", n, 32'd16);
    check_all_zero("midrst_clear_q");

    // Random traffic against the model, with occasional clear requests
    for (int k = 0; k < 400; k++) begin
      we        = 1'($urandom_range(0, 1));
      be        = 4'($urandom);
      addr      = AW'($urandom);
      d         = $urandom;
      disp_re   = 1'($urandom_range(0, 1));
      disp_addr = AW'($urandom);
      clr_req   = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
